// File: rtl/cia_timer_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cia_timer_port                                               |
// | Description : 6526-style CIA subset for the 6502 bus: Timer A, Timer B,    |
// |               ICR flags/mask, CRA, CRB. Registered read data, active-high  |
// |               IRQ output.                                                  |
// | Options     : `define CIA_TIMER_CASCADE_EN lets Timer B count Timer A      |
// |               underflows (CRB INMODE=10).                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cia_timer_port #(
  parameter int TICK_DIV = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [3:0] addr,
  input  logic       we,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic       irq
);

  localparam int                 c_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [15:0]        r_la, r_lb, r_ta, r_tb;
  logic               r_cra_start, r_cra_oneshot, r_cra_b5;
  logic               r_crb_start, r_crb_oneshot;
`ifdef CIA_TIMER_CASCADE_EN
  logic [1:0]         r_crb_inmode;
`endif
  logic [1:0]         r_flags, r_mask;
  logic               r_irq;
  logic [7:0]         r_dout;

  logic        w_tick, w_wr, w_rd, w_icr_rd;
  logic        w_ta_load, w_tb_load, w_ta_cnt, w_tb_cnt, w_ta_uf, w_tb_uf;
  logic [15:0] w_ta_nxt, w_tb_nxt;
  logic [1:0]  w_flags_nxt, w_mask_nxt;
  logic [7:0]  w_rd_data;

  assign w_tick   = (r_div == c_DIV_MAX);
  assign w_wr     = cs & we;
  assign w_rd     = cs & ~we;
  assign w_icr_rd = w_rd && (addr == 4'hD);

  // Emulated phi2 divider: one tick every TICK_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Next counter, flag and mask values; CPU loads outrank underflow reload.
  always_comb begin
    w_ta_load = w_wr && ((addr == 4'h5 && !r_cra_start) || (addr == 4'hE && di[4]));
    w_tb_load = w_wr && ((addr == 4'h7 && !r_crb_start) || (addr == 4'hF && di[4]));
    w_ta_cnt  = r_cra_start && w_tick;
`ifdef CIA_TIMER_CASCADE_EN
    case (r_crb_inmode)
      2'b00:   w_tb_cnt = r_crb_start && w_tick;
      2'b10:   w_tb_cnt = r_crb_start && w_ta_cnt && (r_ta == 16'h0) && !w_ta_load;
      default: w_tb_cnt = 1'b0;
    endcase
`else
    w_tb_cnt  = r_crb_start && w_tick;
`endif
    w_ta_uf   = w_ta_cnt && (r_ta == 16'h0) && !w_ta_load;
    w_tb_uf   = w_tb_cnt && (r_tb == 16'h0) && !w_tb_load;

    w_ta_nxt = r_ta;
    if (w_ta_load)     w_ta_nxt = (addr == 4'h5) ? {di, r_la[7:0]} : r_la;
    else if (w_ta_uf)  w_ta_nxt = r_la;
    else if (w_ta_cnt) w_ta_nxt = r_ta - 16'd1;

    w_tb_nxt = r_tb;
    if (w_tb_load)     w_tb_nxt = (addr == 4'h7) ? {di, r_lb[7:0]} : r_lb;
    else if (w_tb_uf)  w_tb_nxt = r_lb;
    else if (w_tb_cnt) w_tb_nxt = r_tb - 16'd1;

    // A flag set in the same edge as the ICR read clear survives.
    w_flags_nxt = (w_icr_rd ? 2'b00 : r_flags) | {w_tb_uf, w_ta_uf};

    w_mask_nxt = r_mask;
    if (w_wr && addr == 4'hD) w_mask_nxt = di[7] ? (r_mask | di[1:0]) : (r_mask & ~di[1:0]);
  end

  // Read mux over the current (pre-edge) register state.
  always_comb begin
    w_rd_data = 8'h00;
    case (addr)
      4'h4: w_rd_data = r_ta[7:0];
      4'h5: w_rd_data = r_ta[15:8];
      4'h6: w_rd_data = r_tb[7:0];
      4'h7: w_rd_data = r_tb[15:8];
      4'hD: w_rd_data = {|(r_flags & r_mask), 5'b0, r_flags};
      4'hE: w_rd_data = {2'b00, r_cra_b5, 1'b0, r_cra_oneshot, 2'b00, r_cra_start};
`ifdef CIA_TIMER_CASCADE_EN
      4'hF: w_rd_data = {1'b0, r_crb_inmode, 1'b0, r_crb_oneshot, 2'b00, r_crb_start};
`else
      4'hF: w_rd_data = {4'b0000, r_crb_oneshot, 2'b00, r_crb_start};
`endif
      default: w_rd_data = 8'h00;
    endcase
  end

  // Architectural state: counters, latches, control, ICR, irq and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_la          <= 16'hFFFF;
      r_lb          <= 16'hFFFF;
      r_ta          <= 16'hFFFF;
      r_tb          <= 16'hFFFF;
      r_cra_start   <= 1'b0;
      r_cra_oneshot <= 1'b0;
      r_cra_b5      <= 1'b0;
      r_crb_start   <= 1'b0;
      r_crb_oneshot <= 1'b0;
`ifdef CIA_TIMER_CASCADE_EN
      r_crb_inmode  <= 2'b00;
`endif
      r_flags       <= 2'b00;
      r_mask        <= 2'b00;
      r_irq         <= 1'b0;
      r_dout        <= 8'h00;
    end else begin
      r_ta    <= w_ta_nxt;
      r_tb    <= w_tb_nxt;
      r_flags <= w_flags_nxt;
      r_mask  <= w_mask_nxt;
      r_irq   <= |(w_flags_nxt & w_mask_nxt);
      if (w_rd) r_dout <= w_rd_data;
      // One-shot stop; a control-register write in the same edge overrides it.
      if (w_ta_uf && r_cra_oneshot) r_cra_start <= 1'b0;
      if (w_tb_uf && r_crb_oneshot) r_crb_start <= 1'b0;
      if (w_wr) begin
        case (addr)
          4'h4: r_la[7:0]  <= di;
          4'h5: r_la[15:8] <= di;
          4'h6: r_lb[7:0]  <= di;
          4'h7: r_lb[15:8] <= di;
          4'hE: begin
            r_cra_start   <= di[0];
            r_cra_oneshot <= di[3];
            r_cra_b5      <= di[5];
          end
          4'hF: begin
            r_crb_start   <= di[0];
            r_crb_oneshot <= di[3];
`ifdef CIA_TIMER_CASCADE_EN
            r_crb_inmode  <= di[6:5];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule
`default_nettype wire
